adder_ripple_carry_4b_gl: RTL and testbench

ADDER_RIPPLE_CARRY_4B_GL -- requirements
Module: adder_ripple_carry_4b_gl

---
 rtl/adder_ripple_carry_4b_gl.sv | 58 +++++
 tb/tb_adder_ripple_carry_4b_gl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/adder_ripple_carry_4b_gl.sv
// 4-bit ripple-carry adder built from gate-level full-adder cells.
// Purely combinational; clk and reset exist only for harness uniformity.

// One-bit full adder from gate primitives: propagate, generate, carry merge.
module full_adder_gl (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    xor u_xor_p (p, a, b);
    xor u_xor_s (sum, p, cin);
    and u_and_g (g, a, b);
    and u_and_t (t, cin, p);
    or  u_or_c  (cout, g, t);

endmodule

module adder_ripple_carry_4b_gl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    localparam int unsigned W = 4;

    logic [W:0] c;

    // clk and reset intentionally have no effect on the datapath.
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};

    assign c[0] = cin;

    // Carry ripples strictly from stage 0 upward.
    for (genvar i = 0; i < W; i++) begin : g_stage
        full_adder_gl u_fa (
            .a    (in0[i]),
            .b    (in1[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[W];

endmodule

// File: tb/tb_adder_ripple_carry_4b_gl.sv
// Scoreboard bench for adder_ripple_carry_4b_gl: directed corners, exhaustive
// shuffled sweep and random vectors with reset toggling in the background.
module tb_adder_ripple_carry_4b_gl;

    logic       clk;
    logic       reset;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] exp;
    } vec_t;

    vec_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    logic rst_toggle = 1'b0;

    adder_ripple_carry_4b_gl dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reset chatter at a period unrelated to the clock.
    always #7 if (rst_toggle) reset = ~reset;

    function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        int unsigned total;
        total = int'(a) + int'(b) + int'(c);
        return 5'(total);
    endfunction

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [4:0] exp);
        vec_t v;
        @(posedge clk);
        #1;
        in0 = a;
        in1 = b;
        cin = c;
        v.a = a;
        v.b = b;
        v.c = c;
        v.exp = exp;
        q.push_back(v);
        n_pushed++;
    endtask

    // Monitor: outputs sampled 9 time units after each input change.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            vec_t   v;
            logic [4:0] act;
            v = q.pop_front();
            act = {cout, sum};
            n_tests++;
            if (act !== v.exp) begin
                n_fail++;
                $display("FAIL add a=%0d b=%0d cin=%0d reset=%b: got {cout,sum}=%b, expected %b",
                         v.a, v.b, v.c, reset, act, v.exp);
            end
        end
    end

    logic [3:0] da [10] = '{4'd0, 4'd1, 4'd0, 4'd8, 4'd8, 4'd15, 4'd15, 4'd4, 4'd2, 4'd0};
    logic [3:0] db [10] = '{4'd0, 4'd1, 4'd0, 4'd8, 4'd8, 4'd15, 4'd0,  4'd4, 4'd0, 4'd4};
    logic       dc [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,  1'b1,  1'b0, 1'b0, 1'b0};
    logic [4:0] de [10] = '{5'b00000, 5'b00010, 5'b00001, 5'b10000, 5'b10001,
                            5'b11111, 5'b10000, 5'b01000, 5'b00010, 5'b00100};

    initial begin
        void'($urandom(32'd20240611));
        reset = 1'b1;
        in0 = 4'd0;
        in1 = 4'd0;
        cin = 1'b0;

        // Directed corners; the first two are applied with reset held high.
        for (int i = 0; i < 10; i++) begin
            if (i == 2) reset = 1'b0;
            apply(da[i], db[i], dc[i], de[i]);
        end

        // Exhaustive sweep in a scrambled order, reset chattering throughout.
        rst_toggle = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            idx = 9'((i * 167 + 53) % 512);
            apply(idx[8:5], idx[4:1], idx[0], ref_sum(idx[8:5], idx[4:1], idx[0]));
        end

        // Random vectors with reset driven randomly per vector.
        rst_toggle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            reset = 1'($urandom_range(0, 1));
            apply(a, b, c, ref_sum(a, b, c));
        end
        reset = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (q.size() != 0 || n_pushed != n_tests - 1) begin
            n_fail++;
            $display("FAIL drain: %0d pending, %0d checked, %0d pushed",
                     q.size(), n_tests - 1, n_pushed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, %0d checked", n_tests);
        $fatal(1, "timeout");
    end

endmodule
